clkset_sequencer: RTL and testbench

//  Sequences clock-mode changes and core resets between the core's cfg register and the clock generator.

---
 rtl/clkset_sequencer_if.sv | 43 ++++
 rtl/clkset_sequencer.sv | 142 ++++++++++++++
 tb/tb_clkset_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/clkset_sequencer_if.sv
// rtl/clkset_sequencer_if.sv - cfg/reset bundle between core cfg, sequencer and clock generator
// The pll_locked signal exists only when CLKSET_LOCK_EN is defined.
interface clkset_sequencer_if;
    logic [7:0] cfg_in;
`ifdef CLKSET_LOCK_EN
    logic       pll_locked;
`endif
    logic [6:0] cfg_out;
    logic       core_nres;
    logic       busy;

`ifdef CLKSET_LOCK_EN
    modport slave (
        input  cfg_in,
        input  pll_locked,
        output cfg_out,
        output core_nres,
        output busy
    );

    modport master (
        output cfg_in,
        output pll_locked,
        input  cfg_out,
        input  core_nres,
        input  busy
    );
`else
    modport slave (
        input  cfg_in,
        output cfg_out,
        output core_nres,
        output busy
    );

    modport master (
        output cfg_in,
        input  cfg_out,
        input  core_nres,
        input  busy
    );
`endif
endinterface

// File: rtl/clkset_sequencer.sv
// rtl/clkset_sequencer.sv - glitch-safe clock-mode and core-reset sequencer
// CLKSET_LOCK_EN: PLLWAIT also exits early on a synchronized pll_locked.
module clkset_sequencer #(
    parameter int RESET_CYCLES    = 16,
    parameter int PLL_LOCK_CYCLES = 1_600_000,
    parameter int CNT_W           = 24
) (
    input  logic              clock_160,
    input  logic              nres,
    clkset_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        IDLE    = 2'd1,
        SWRST   = 2'd2,
        PLLWAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLL_LOAD   = CNT_W'(PLL_LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       sync1_q, sync1_d;
    logic [7:0]       sync2_q, sync2_d;
    logic [7:0]       cfg_s_q, cfg_s_d;
    logic [6:0]       cfg_out_q, cfg_out_d;
    logic             core_nres_q, core_nres_d;
    logic             busy_q, busy_d;
    logic             pll_done;

`ifdef CLKSET_LOCK_EN
    logic lock1_q, lock1_d;
    logic lock2_q, lock2_d;

    always_comb begin
        lock1_d  = bus.pll_locked;
        lock2_d  = lock1_q;
        pll_done = (cnt_q == '0) || lock2_q;
    end

    always_ff @(posedge clock_160) begin
        if (!nres) begin
            lock1_q <= 1'b0;
            lock2_q <= 1'b0;
        end else begin
            lock1_q <= lock1_d;
            lock2_q <= lock2_d;
        end
    end
`else
    always_comb begin
        pll_done = (cnt_q == '0);
    end
`endif

    always_comb begin
        sync1_d = bus.cfg_in;
        sync2_d = sync1_q;
        // Accept a synchronized value only once it has been seen on two consecutive cycles.
        cfg_s_d = (sync1_q == sync2_q) ? sync2_q : cfg_s_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_out_d   = cfg_out_q;
        core_nres_d = core_nres_q;

        case (state_q)
            HOLD, SWRST: begin
                core_nres_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    core_nres_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            IDLE: begin
                if (cfg_s_q[7]) begin
                    state_d     = SWRST;
                    cfg_out_d   = cfg_s_q[6:0];
                    core_nres_d = 1'b0;
                    cnt_d       = RESET_LOAD;
                end else if (cfg_s_q[6] && !cfg_out_q[6] && (cfg_s_q[2:0] >= 3'd3)) begin
                    // Enable the PLL now but keep the old CLKSEL until it has settled.
                    state_d   = PLLWAIT;
                    cfg_out_d = {cfg_s_q[6:3], cfg_out_q[2:0]};
                    cnt_d     = PLL_LOAD;
                end else begin
                    cfg_out_d = cfg_s_q[6:0];
                end
            end
            PLLWAIT: begin
                if (cfg_s_q[7]) begin
                    state_d     = SWRST;
                    cfg_out_d   = cfg_s_q[6:0];
                    core_nres_d = 1'b0;
                    cnt_d       = RESET_LOAD;
                end else if (pll_done) begin
                    state_d   = IDLE;
                    cfg_out_d = {cfg_out_q[6:3], cfg_s_q[2:0]};
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_160) begin
        if (!nres) begin
            state_q     <= HOLD;
            cnt_q       <= RESET_LOAD;
            sync1_q     <= '0;
            sync2_q     <= '0;
            cfg_s_q     <= '0;
            cfg_out_q   <= '0;
            core_nres_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cfg_s_q     <= cfg_s_d;
            cfg_out_q   <= cfg_out_d;
            core_nres_q <= core_nres_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cfg_out   = cfg_out_q;
    assign bus.core_nres = core_nres_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_clkset_sequencer.sv
// tb/tb_clkset_sequencer.sv - directed bench for clkset_sequencer (PLL wait set to 20 cycles)
module tb_clkset_sequencer;

    logic clk = 1'b0;
    logic nres;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    clkset_sequencer_if bus0();
    clkset_sequencer_if bus1();

    clkset_sequencer #(
        .RESET_CYCLES    (16),
        .PLL_LOCK_CYCLES (20),
        .CNT_W           (24)
    ) dut (
        .clock_160 (clk),
        .nres      (nres),
        .bus       (bus0)
    );

    clkset_sequencer #(
        .RESET_CYCLES    (1),
        .PLL_LOCK_CYCLES (20),
        .CNT_W           (24)
    ) dut_min (
        .clock_160 (clk),
        .nres      (nres),
        .bus       (bus1)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int r0;
        int r1;
        nres = 1'b0;
        tick(5);
        tests_run++; if (bus0.core_nres !== 1'b0) begin tests_failed++; $display("FAIL reset_core_nres got=%b exp=0", bus0.core_nres); end
        tests_run++; if (bus0.busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy got=%b exp=1", bus0.busy); end
        tests_run++; if (bus0.cfg_out !== 7'h00) begin tests_failed++; $display("FAIL reset_cfg_out got=%h exp=00", bus0.cfg_out); end
        nres = 1'b1;
        r0 = 0;
        r1 = 0;
        for (int k = 1; k <= 40 && (r0 == 0 || r1 == 0); k++) begin
            tick();
            if (r0 == 0 && bus0.core_nres === 1'b1) r0 = k;
            if (r1 == 0 && bus1.core_nres === 1'b1) r1 = k;
        end
        tests_run++; if (r0 != 16) begin tests_failed++; $display("FAIL reset_release_len got=%0d exp=16", r0); end
        tests_run++; if (r1 != 1) begin tests_failed++; $display("FAIL reset_min_len got=%0d exp=1", r1); end
        tick();
        tests_run++; if (bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_after got=%b exp=0", bus0.busy); end
        tests_run++; if (bus0.cfg_out !== 7'h00) begin tests_failed++; $display("FAIL reset_cfg_after got=%h exp=00", bus0.cfg_out); end
    endtask

    task automatic test_idle_update();
        bus0.cfg_in = 8'h08;
        tick(3);
        tests_run++; if (bus0.cfg_out !== 7'h00) begin tests_failed++; $display("FAIL idle_early got=%h exp=00", bus0.cfg_out); end
        tick();
        tests_run++; if (bus0.cfg_out !== 7'h08) begin tests_failed++; $display("FAIL idle_apply got=%h exp=08", bus0.cfg_out); end
        tests_run++; if (bus0.core_nres !== 1'b1 || bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_flags got=%b%b exp=10", bus0.core_nres, bus0.busy); end
        // PLL enable with CLKSEL below 3 is an ordinary update
        bus0.cfg_in = 8'h62;
        tick(4);
        tests_run++; if (bus0.cfg_out !== 7'h62 || bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_clksel2 got=%h/%b exp=62/0", bus0.cfg_out, bus0.busy); end
        bus0.cfg_in = 8'h00;
        tick(6);
        tests_run++; if (bus0.cfg_out !== 7'h00) begin tests_failed++; $display("FAIL idle_clear got=%h exp=00", bus0.cfg_out); end
    endtask

    task automatic test_pll_timeout();
        bus0.cfg_in = 8'h6F;
        tick(4);
        tests_run++; if (bus0.cfg_out !== 7'h68 || bus0.busy !== 1'b1) begin tests_failed++; $display("FAIL pll_enter got=%h/%b exp=68/1", bus0.cfg_out, bus0.busy); end
        tick(19);
        tests_run++; if (bus0.cfg_out !== 7'h68 || bus0.busy !== 1'b1) begin tests_failed++; $display("FAIL pll_hold got=%h/%b exp=68/1", bus0.cfg_out, bus0.busy); end
        tick();
        tests_run++; if (bus0.cfg_out !== 7'h6F || bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL pll_expire got=%h/%b exp=6F/0", bus0.cfg_out, bus0.busy); end
    endtask

    task automatic test_pll_late_change();
        bus0.cfg_in = 8'h00;
        tick(6);
        bus0.cfg_in = 8'h6B;
        tick(4);
        tests_run++; if (bus0.cfg_out !== 7'h68) begin tests_failed++; $display("FAIL late_enter got=%h exp=68", bus0.cfg_out); end
        tick(4);
        bus0.cfg_in = 8'h7E;
        tick(15);
        tests_run++; if (bus0.cfg_out !== 7'h68) begin tests_failed++; $display("FAIL late_ignored got=%h exp=68", bus0.cfg_out); end
        tick();
        tests_run++; if (bus0.cfg_out !== 7'h6E) begin tests_failed++; $display("FAIL late_clksel got=%h exp=6E", bus0.cfg_out); end
        tick();
        tests_run++; if (bus0.cfg_out !== 7'h7E) begin tests_failed++; $display("FAIL late_idle_upd got=%h exp=7E", bus0.cfg_out); end
    endtask

    task automatic test_swrst_abort();
        int r;
        bus0.cfg_in = 8'h00;
        tick(6);
        bus0.cfg_in = 8'h6F;
        tick(6);
        bus0.cfg_in = 8'hEF;
        tick(3);
        tests_run++; if (bus0.cfg_out !== 7'h68 || bus0.core_nres !== 1'b1) begin tests_failed++; $display("FAIL swrst_before got=%h/%b exp=68/1", bus0.cfg_out, bus0.core_nres); end
        tick();
        tests_run++; if (bus0.cfg_out !== 7'h6F || bus0.core_nres !== 1'b0 || bus0.busy !== 1'b1) begin tests_failed++; $display("FAIL swrst_enter got=%h/%b/%b exp=6F/0/1", bus0.cfg_out, bus0.core_nres, bus0.busy); end
        bus0.cfg_in = 8'h00;
        r = 0;
        for (int k = 1; k <= 40 && r == 0; k++) begin
            tick();
            if (bus0.core_nres === 1'b1) r = k;
        end
        tests_run++; if (r != 16) begin tests_failed++; $display("FAIL swrst_len got=%0d exp=16", r); end
        tests_run++; if (bus0.cfg_out !== 7'h6F) begin tests_failed++; $display("FAIL swrst_exit_cfg got=%h exp=6F", bus0.cfg_out); end
        tick();
        tests_run++; if (bus0.cfg_out !== 7'h00) begin tests_failed++; $display("FAIL swrst_cleared got=%h exp=00", bus0.cfg_out); end
    endtask

    task automatic test_reset_mid_pll();
        int r;
        int bad;
        bus0.cfg_in = 8'h6F;
        tick(10);
        nres = 1'b0;
        bus0.cfg_in = 8'h00;
        tick();
        tests_run++; if (bus0.cfg_out !== 7'h00 || bus0.core_nres !== 1'b0 || bus0.busy !== 1'b1) begin tests_failed++; $display("FAIL midpll_reset got=%h/%b/%b exp=00/0/1", bus0.cfg_out, bus0.core_nres, bus0.busy); end
        tick();
        nres = 1'b1;
        r = 0;
        bad = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (r == 0 && bus0.core_nres === 1'b1) r = k;
            if (bus0.cfg_out !== 7'h00) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL midpll_no_switch got=%0d nonzero cycles exp=0", bad); end
        tests_run++; if (r != 16) begin tests_failed++; $display("FAIL midpll_hold_len got=%0d exp=16", r); end
    endtask

`ifdef CLKSET_LOCK_EN
    task automatic test_lock();
        bus0.cfg_in = 8'h6F;
        tick(4);
        tests_run++; if (bus0.cfg_out !== 7'h68) begin tests_failed++; $display("FAIL lock_enter got=%h exp=68", bus0.cfg_out); end
        tick(5);
        bus0.pll_locked = 1'b1;
        tick(2);
        tests_run++; if (bus0.cfg_out !== 7'h68) begin tests_failed++; $display("FAIL lock_early got=%h exp=68", bus0.cfg_out); end
        tick();
        tests_run++; if (bus0.cfg_out !== 7'h6F || bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL lock_apply got=%h/%b exp=6F/0", bus0.cfg_out, bus0.busy); end
        bus0.pll_locked = 1'b0;
        bus0.cfg_in = 8'h00;
        tick(6);
    endtask
`endif

    initial begin
        nres = 1'b0;
        bus0.cfg_in = 8'h00;
        bus1.cfg_in = 8'h00;
`ifdef CLKSET_LOCK_EN
        bus0.pll_locked = 1'b0;
        bus1.pll_locked = 1'b0;
`endif
        test_reset();
        test_idle_update();
        test_pll_timeout();
        test_pll_late_change();
        test_swrst_abort();
        test_reset_mid_pll();
`ifdef CLKSET_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
